// File: rtl/fp_operand_join.sv
// ----------------------------------------------------------------------------
// fp_operand_join
// Operand-pairing stage in front of the sequential half/float units.
// The A and B operand streams are buffered in two independent FIFOs and
// released strictly in arrival order as matched pairs. Both m_* valids are
// asserted in the same cycle, so units whose valids must coincide can be
// fed by producers with skewed A/B timing.
//
// Ports
//   aclk, aresetn      clock (rising edge); asynchronous active-high reset
//   s_axis_a_*         operand A input stream (tready = A FIFO not full)
//   s_axis_b_*         operand B input stream (tready = B FIFO not full)
//   m_axis_a_*         paired operand A output (registered)
//   m_axis_b_*         paired operand B output (registered)
//   m_axis_tready      downstream accepts the pair (tie to 1 for the divider)
//   count_a, count_b   FIFO occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module fp_operand_join #(
   parameter int EXP = 5,
   parameter int FRA = 10,
   parameter int AW  = 2
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [EXP+FRA:0]   s_axis_a_tdata,
   input  logic               s_axis_a_tvalid,
   output logic               s_axis_a_tready,
   input  logic [EXP+FRA:0]   s_axis_b_tdata,
   input  logic               s_axis_b_tvalid,
   output logic               s_axis_b_tready,
   output logic [EXP+FRA:0]   m_axis_a_tdata,
   output logic               m_axis_a_tvalid,
   output logic [EXP+FRA:0]   m_axis_b_tdata,
   output logic               m_axis_b_tvalid,
   input  logic               m_axis_tready,
   output logic [AW:0]        count_a,
   output logic [AW:0]        count_b
);

   localparam int          W        = EXP + FRA + 1;
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   // Storage is never reset: pointers and counts alone define what is valid.
   logic [W-1:0]  mem_a_q [DEPTH];
   logic [W-1:0]  mem_b_q [DEPTH];

   logic [AW-1:0] wr_ptr_a_q, wr_ptr_a_d, rd_ptr_a_q, rd_ptr_a_d;
   logic [AW-1:0] wr_ptr_b_q, wr_ptr_b_d, rd_ptr_b_q, rd_ptr_b_d;
   logic [AW:0]   count_a_q, count_a_d, count_b_q, count_b_d;
   logic [W-1:0]  m_a_q, m_a_d, m_b_q, m_b_d;
   logic          m_valid_q, m_valid_d;

   logic          push_a, push_b, load;

   // tready depends only on the registered count (and reset), never on
   // m_axis_tready, so a pop cannot free a slot for a same-cycle write.
   assign s_axis_a_tready = !aresetn && (count_a_q != FULL_CNT);
   assign s_axis_b_tready = !aresetn && (count_b_q != FULL_CNT);

   assign push_a = s_axis_a_tvalid && s_axis_a_tready;
   assign push_b = s_axis_b_tvalid && s_axis_b_tready;

   // A pair is released only when both sides hold an entry and the output
   // register is empty or being drained this cycle.
   assign load = (count_a_q != '0) && (count_b_q != '0) &&
                 (!m_valid_q || m_axis_tready);

   always_comb begin
      wr_ptr_a_d = wr_ptr_a_q;
      wr_ptr_b_d = wr_ptr_b_q;
      rd_ptr_a_d = rd_ptr_a_q;
      rd_ptr_b_d = rd_ptr_b_q;
      m_a_d      = m_a_q;
      m_b_d      = m_b_q;
      m_valid_d  = m_valid_q;

      if (push_a) wr_ptr_a_d = wr_ptr_a_q + AW'(1);
      if (push_b) wr_ptr_b_d = wr_ptr_b_q + AW'(1);

      if (load) begin
         rd_ptr_a_d = rd_ptr_a_q + AW'(1);
         rd_ptr_b_d = rd_ptr_b_q + AW'(1);
         m_a_d      = mem_a_q[rd_ptr_a_q];
         m_b_d      = mem_b_q[rd_ptr_b_q];
         m_valid_d  = 1'b1;
      end else if (m_axis_tready) begin
         m_valid_d  = 1'b0;
      end

      count_a_d = count_a_q + (AW+1)'(push_a) - (AW+1)'(load);
      count_b_d = count_b_q + (AW+1)'(push_b) - (AW+1)'(load);
   end

   always_ff @(posedge aclk) begin
      if (push_a) mem_a_q[wr_ptr_a_q] <= s_axis_a_tdata;
      if (push_b) mem_b_q[wr_ptr_b_q] <= s_axis_b_tdata;
   end

   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         wr_ptr_a_q <= '0;
         wr_ptr_b_q <= '0;
         rd_ptr_a_q <= '0;
         rd_ptr_b_q <= '0;
         count_a_q  <= '0;
         count_b_q  <= '0;
         m_a_q      <= '0;
         m_b_q      <= '0;
         m_valid_q  <= 1'b0;
      end else begin
         wr_ptr_a_q <= wr_ptr_a_d;
         wr_ptr_b_q <= wr_ptr_b_d;
         rd_ptr_a_q <= rd_ptr_a_d;
         rd_ptr_b_q <= rd_ptr_b_d;
         count_a_q  <= count_a_d;
         count_b_q  <= count_b_d;
         m_a_q      <= m_a_d;
         m_b_q      <= m_b_d;
         m_valid_q  <= m_valid_d;
      end
   end

   assign m_axis_a_tdata  = m_a_q;
   assign m_axis_b_tdata  = m_b_q;
   assign m_axis_a_tvalid = m_valid_q;
   assign m_axis_b_tvalid = m_valid_q;
   assign count_a         = count_a_q;
   assign count_b         = count_b_q;

endmodule

// File: tb/tb_fp_operand_join.sv
// ----------------------------------------------------------------------------
// tb_fp_operand_join
// Directed-vector bench for fp_operand_join (EXP=5, FRA=10, AW=2).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_fp_operand_join;

   localparam int EXP = 5;
   localparam int FRA = 10;
   localparam int AW  = 2;
   localparam int W   = EXP + FRA + 1;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [W-1:0]  s_axis_a_tdata, s_axis_b_tdata;
   logic          s_axis_a_tvalid, s_axis_b_tvalid;
   logic          s_axis_a_tready, s_axis_b_tready;
   logic [W-1:0]  m_axis_a_tdata, m_axis_b_tdata;
   logic          m_axis_a_tvalid, m_axis_b_tvalid;
   logic          m_axis_tready;
   logic [AW:0]   count_a, count_b;

   int n_cmp = 0;
   int n_bad = 0;

   fp_operand_join #(.EXP(EXP), .FRA(FRA), .AW(AW)) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .s_axis_a_tdata  (s_axis_a_tdata),
      .s_axis_a_tvalid (s_axis_a_tvalid),
      .s_axis_a_tready (s_axis_a_tready),
      .s_axis_b_tdata  (s_axis_b_tdata),
      .s_axis_b_tvalid (s_axis_b_tvalid),
      .s_axis_b_tready (s_axis_b_tready),
      .m_axis_a_tdata  (m_axis_a_tdata),
      .m_axis_a_tvalid (m_axis_a_tvalid),
      .m_axis_b_tdata  (m_axis_b_tdata),
      .m_axis_b_tvalid (m_axis_b_tvalid),
      .m_axis_tready   (m_axis_tready),
      .count_a         (count_a),
      .count_b         (count_b)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic va, input logic [W-1:0] da,
                        input logic vb, input logic [W-1:0] db);
      s_axis_a_tvalid = va;
      s_axis_a_tdata  = da;
      s_axis_b_tvalid = vb;
      s_axis_b_tdata  = db;
   endtask

   task automatic chk_pair(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
      chk({tag, "_va"}, 32'(m_axis_a_tvalid), 32'd1);
      chk({tag, "_vb"}, 32'(m_axis_b_tvalid), 32'd1);
      chk({tag, "_a"},  32'(m_axis_a_tdata), 32'(ea));
      chk({tag, "_b"},  32'(m_axis_b_tdata), 32'(eb));
   endtask

   logic [W-1:0] vec_a [3] = '{16'h3C00, 16'h4000, 16'h4200};
   logic [W-1:0] vec_b [3] = '{16'h4000, 16'h3C00, 16'h4400};

   initial begin
      int k, ia, ib;
      logic acc_a, acc_b, stalled, tog;
      logic [W-1:0] held_a, held_b;

      // ---------------- reset state ----------------
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      drive(1'b0, '0, 1'b0, '0);
      step(); step();
      chk("rst_tready_a", 32'(s_axis_a_tready), 32'd0);
      chk("rst_tready_b", 32'(s_axis_b_tready), 32'd0);
      chk("rst_mvalid",   32'(m_axis_a_tvalid), 32'd0);
      chk("rst_mdata_a",  32'(m_axis_a_tdata), 32'd0);
      chk("rst_count_a",  32'(count_a), 32'd0);
      aresetn = 1'b0;
      #1;
      chk("rel_tready_a", 32'(s_axis_a_tready), 32'd1);
      chk("rel_tready_b", 32'(s_axis_b_tready), 32'd1);
      step();

      // ---------------- aligned stream ----------------
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, vec_a[i], 1'b1, vec_b[i]);
         step();
         if (i == 0) chk("al_nobypass", 32'(m_axis_a_tvalid), 32'd0);
         else        chk_pair($sformatf("al_p%0d", i - 1), vec_a[i-1], vec_b[i-1]);
      end
      drive(1'b0, '0, 1'b0, '0);
      step();
      chk_pair("al_p2", vec_a[2], vec_b[2]);
      step();
      chk("al_done_v", 32'(m_axis_a_tvalid), 32'd0);
      chk("al_done_ca", 32'(count_a), 32'd0);

      // ---------------- skewed arrival ----------------
      drive(1'b1, 16'h4500, 1'b0, '0);
      step();
      drive(1'b0, '0, 1'b0, '0);
      for (int c = 1; c <= 5; c++) begin
         chk($sformatf("sk_ca_c%0d", c), 32'(count_a), 32'd1);
         chk($sformatf("sk_v_c%0d", c),  32'(m_axis_a_tvalid), 32'd0);
         if (c < 5) step();
      end
      drive(1'b0, '0, 1'b1, 16'h3800);
      step();
      drive(1'b0, '0, 1'b0, '0);
      chk("sk_v_acc", 32'(m_axis_b_tvalid), 32'd0);
      chk("sk_cb_acc", 32'(count_b), 32'd1);
      step();
      chk_pair("sk_pair", 16'h4500, 16'h3800);
      chk("sk_ca_end", 32'(count_a), 32'd0);
      step();
      chk("sk_v_end", 32'(m_axis_a_tvalid), 32'd0);

      // ---------------- fill / backpressure ----------------
      m_axis_tready = 1'b0;
      drive(1'b1, 16'h1001, 1'b1, 16'h2001);
      step();
      for (int i = 2; i <= 5; i++) begin
         drive(1'b1, W'(16'h1000 + i), 1'b0, '0);
         step();
      end
      chk("fi_ca4", 32'(count_a), 32'd4);
      chk("fi_rdy0", 32'(s_axis_a_tready), 32'd0);
      chk_pair("fi_held", 16'h1001, 16'h2001);
      for (int i = 2; i <= 5; i++) begin
         drive(1'b1, 16'h1006, 1'b1, W'(16'h2000 + i));
         step();
      end
      drive(1'b1, 16'h1006, 1'b0, '0);
      chk("fi_ca_still4", 32'(count_a), 32'd4);
      chk("fi_cb4", 32'(count_b), 32'd4);
      chk_pair("fi_held2", 16'h1001, 16'h2001);
      m_axis_tready = 1'b1;
      step();
      drive(1'b0, '0, 1'b0, '0);
      chk_pair("fi_d2", 16'h1002, 16'h2002);
      chk("fi_rdy1", 32'(s_axis_a_tready), 32'd1);
      chk("fi_nowrite_full", 32'(count_a), 32'd3);
      for (int i = 3; i <= 5; i++) begin
         step();
         chk_pair($sformatf("fi_d%0d", i), W'(16'h1000 + i), W'(16'h2000 + i));
      end
      step();
      chk("fi_end_v", 32'(m_axis_a_tvalid), 32'd0);
      chk("fi_end_ca", 32'(count_a), 32'd0);
      chk("fi_end_cb", 32'(count_b), 32'd0);

      // ---------------- wrap-around with toggling tready ----------------
      k = 0; ia = 0; ib = 0; stalled = 1'b0; tog = 1'b1;
      held_a = '0; held_b = '0;
      for (int cyc = 0; cyc < 80 && k < 10; cyc++) begin
         if (stalled) begin
            chk("wr_hold_v", 32'(m_axis_a_tvalid), 32'd1);
            chk("wr_hold_a", 32'(m_axis_a_tdata), 32'(held_a));
            chk("wr_hold_b", 32'(m_axis_b_tdata), 32'(held_b));
         end
         m_axis_tready = tog;
         tog = ~tog;
         stalled = 1'b0;
         if (m_axis_a_tvalid) begin
            if (m_axis_tready) begin
               chk($sformatf("wr_a%0d", k), 32'(m_axis_a_tdata), 32'h3000 + 32'(k));
               chk($sformatf("wr_b%0d", k), 32'(m_axis_b_tdata), 32'h5000 + 32'(k));
               k++;
            end else begin
               stalled = 1'b1;
               held_a = m_axis_a_tdata;
               held_b = m_axis_b_tdata;
            end
         end
         drive(ia < 10, W'(16'h3000 + ia), ib < 10, W'(16'h5000 + ib));
         acc_a = s_axis_a_tvalid && s_axis_a_tready;
         acc_b = s_axis_b_tvalid && s_axis_b_tready;
         step();
         if (acc_a) ia++;
         if (acc_b) ib++;
      end
      chk("wr_all", 32'(k), 32'd10);
      drive(1'b0, '0, 1'b0, '0);
      m_axis_tready = 1'b1;
      step(); step();
      chk("wr_end_v", 32'(m_axis_a_tvalid), 32'd0);
      chk("wr_end_ca", 32'(count_a), 32'd0);
      chk("wr_end_cb", 32'(count_b), 32'd0);

      // ---------------- simultaneous push/pop ----------------
      m_axis_tready = 1'b1;
      drive(1'b1, 16'h4801, 1'b1, 16'h4901);
      step();
      drive(1'b1, 16'h4802, 1'b1, 16'h4902);
      step();
      m_axis_tready = 1'b0;
      drive(1'b1, 16'h4803, 1'b0, '0);
      step();
      chk("pp_ca_before", 32'(count_a), 32'd2);
      chk("pp_cb_before", 32'(count_b), 32'd1);
      m_axis_tready = 1'b1;
      drive(1'b1, 16'h4804, 1'b0, '0);
      step();
      chk("pp_ca_after", 32'(count_a), 32'd2);
      chk_pair("pp_pair", 16'h4802, 16'h4902);

      // ---------------- reset mid-stream ----------------
      m_axis_tready = 1'b0;
      drive(1'b1, 16'h4805, 1'b1, 16'h4903);
      step();
      drive(1'b0, '0, 1'b0, '0);
      chk("mr_ca3", 32'(count_a), 32'd3);
      chk("mr_cb1", 32'(count_b), 32'd1);
      chk("mr_v1", 32'(m_axis_a_tvalid), 32'd1);
      #2;
      aresetn = 1'b1;
      #1;
      chk("mr_v_drop", 32'(m_axis_a_tvalid), 32'd0);
      chk("mr_vb_drop", 32'(m_axis_b_tvalid), 32'd0);
      chk("mr_rdy0", 32'(s_axis_a_tready), 32'd0);
      chk("mr_ca0", 32'(count_a), 32'd0);
      chk("mr_data0", 32'(m_axis_a_tdata), 32'd0);
      step();
      aresetn = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      chk("mr_rel_rdy_a", 32'(s_axis_a_tready), 32'd1);
      chk("mr_rel_rdy_b", 32'(s_axis_b_tready), 32'd1);
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("mr_stale_v%0d", c), 32'(m_axis_a_tvalid), 32'd0);
      end
      chk("mr_end_ca", 32'(count_a), 32'd0);
      chk("mr_end_cb", 32'(count_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
